// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start/data/parity/stop framing with a
// ready/valid output holding one word and an overrun pulse on a dropped frame.
module uart_rx_framer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic [1:0] no_of_bits,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      nbits_q, nbits_d;
    logic            pen_q, pen_d;
    logic            podd_q, podd_d;
    logic            perr_q, perr_d;
    logic            rx_meta_q, rx_s_q;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            mid_bit;

    assign mid_bit = baud_tick && (cnt_q == FullLast);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        nbits_d      = nbits_q;
        pen_d        = pen_q;
        podd_d       = podd_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (baud_tick && !rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    if (cnt_q == HalfLast) begin
                        if (rx_s_q) begin
                            state_d = StIdle;
                        end else begin
                            // Start bit confirmed mid-bit: freeze the frame format here.
                            state_d = StData;
                            cnt_d   = '0;
                            bit_d   = '0;
                            shift_d = '0;
                            perr_d  = 1'b0;
                            nbits_d = no_of_bits;
                            pen_d   = parity_en;
                            podd_d  = parity_odd;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StData: begin
                if (mid_bit) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s_q;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == ({1'b0, nbits_q} + 3'd4)) begin
                        state_d = pen_q ? StParity : StStop;
                    end
                end else if (baud_tick) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                if (mid_bit) begin
                    cnt_d   = '0;
                    perr_d  = ((^shift_q) ^ rx_s_q) != podd_q;
                    state_d = StStop;
                end else if (baud_tick) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (mid_bit) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!rx_valid_q || rx_ready) begin
                        rx_data_d    = shift_q;
                        parity_err_d = perr_q;
                        frame_err_d  = !rx_s_q;
                        rx_valid_d   = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (baud_tick) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            nbits_q      <= '0;
            pen_q        <= 1'b0;
            podd_q       <= 1'b0;
            perr_q       <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            nbits_q      <= nbits_d;
            pen_q        <= pen_d;
            podd_q       <= podd_d;
            perr_q       <= perr_d;
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed frames, a frame-level timing model checked
// every cycle, and literal expectations on the directed scenarios.
module tb_uart_rx_framer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] no_of_bits = 2'd3;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_framer #(.OVERSAMPLE(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .no_of_bits (no_of_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // One baud_tick every third clock, changed 1 time unit after the edge.
    initial begin
        forever begin
            repeat (2) @(posedge clock);
            #1 baud_tick = 1'b1;
            @(posedge clock);
            #1 baud_tick = 1'b0;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame outcome and the tick number on which its stop bit is sampled.
    typedef struct {
        int         done;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    frame_t     pend[$];
    int         tick_no = 0;
    bit         started = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ov = 1'b0;
    int         ov_cycles = 0;

    always @(posedge clock) begin
        logic   nv;
        logic   nov;
        frame_t f;
        started <= 1'b1;
        if (baud_tick) tick_no <= tick_no + 1;
        if (!reset) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_perr  <= 1'b0;
            m_ferr  <= 1'b0;
            m_ov    <= 1'b0;
            pend.delete();
        end else begin
            nv  = m_valid;
            nov = 1'b0;
            if (m_valid && rx_ready) nv = 1'b0;
            if (baud_tick && pend.size() > 0 && pend[0].done == tick_no + 1) begin
                f = pend.pop_front();
                if (!m_valid || rx_ready) begin
                    nv = 1'b1;
                    m_data <= f.data;
                    m_perr <= f.perr;
                    m_ferr <= f.ferr;
                end else begin
                    nov = 1'b1;
                end
            end
            m_valid <= nv;
            m_ov    <= nov;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("rx_valid", rx_valid, m_valid);
            check("overrun", overrun, m_ov);
            if (m_valid || !reset) begin
                check("rx_data", rx_data, m_data);
                check("parity_err", parity_err, m_perr);
                check("frame_err", frame_err, m_ferr);
            end
            if (overrun) ov_cycles++;
        end
    end

    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clock); while (baud_tick !== 1'b1);
        end
        #1;
    endtask

    // Sends one frame of nb data bits; bad_par inverts the parity bit.
    task automatic send_frame(input logic [7:0] data, input int nb, input bit pen, input bit podd,
                              input bit bad_par, input bit stop_val, input bit scramble);
        logic [7:0] d;
        logic       pbit;
        int         s;
        frame_t     f;
        d    = data & 8'((1 << nb) - 1);
        pbit = (^d) ^ podd ^ bad_par;
        s    = 1 + nb + (pen ? 1 : 0);
        tick_wait(1);
        no_of_bits = 2'(nb - 5);
        parity_en  = pen;
        parity_odd = podd;
        rx         = 1'b0;
        // Start seen on the next tick, confirmed 8 ticks later, then 16 ticks per bit.
        f.done = tick_no + 9 + 16 * s;
        f.data = d;
        f.perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
        f.ferr = !stop_val;
        pend.push_back(f);
        tick_wait(16);
        if (scramble) begin
            no_of_bits = ~no_of_bits;
            parity_en  = ~pen;
            parity_odd = ~podd;
        end
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            tick_wait(16);
        end
        if (pen) begin
            rx = pbit;
            tick_wait(16);
        end
        rx = stop_val;
        tick_wait(16);
        rx = 1'b1;
    endtask

    task automatic accept_word();
        rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
        check("accept_clears_valid", rx_valid, 1'b0);
    endtask

    initial begin
        int ov_before;
        repeat (3) @(posedge clock);
        #1;
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        reset = 1'b1;
        tick_wait(4);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("a5_valid", rx_valid, 1'b1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_perr", parity_err, 1'b0);
        check("a5_ferr", frame_err, 1'b0);
        check("a5_idle", busy, 1'b0);
        accept_word();

        // 5E1 0x13 with the parity bit forced to 0 (correct even parity would be 1)
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("5e1_data", rx_data, 8'h13);
        check("5e1_perr", parity_err, 1'b1);
        check("5e1_ferr", frame_err, 1'b0);
        accept_word();

        // 4-tick low glitch on the idle line
        tick_wait(1);
        rx = 1'b0;
        tick_wait(2);
        check("glitch_busy_high", busy, 1'b1);
        tick_wait(2);
        rx = 1'b1;
        tick_wait(10);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_no_valid", rx_valid, 1'b0);

        // 8N1 0x3C with a low stop bit
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("3c_data", rx_data, 8'h3C);
        check("3c_ferr", frame_err, 1'b1);
        check("3c_perr", parity_err, 1'b0);
        accept_word();
        tick_wait(24);

        // 7O1 0x45 (3 ones, odd parity bit 0) with config scrambled mid-frame
        send_frame(8'h45, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("7o1_data", rx_data, 8'h45);
        check("7o1_perr", parity_err, 1'b0);
        accept_word();

        // 6N1 0xFF truncates to 0x3F, scrambled config
        send_frame(8'hFF, 6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("6n1_data", rx_data, 8'h3F);
        check("6n1_perr", parity_err, 1'b0);
        accept_word();

        // Back-to-back 0x11, 0x22 without acceptance
        ov_before = ov_cycles;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_held_data", rx_data, 8'h11);
        check("b2b_valid", rx_valid, 1'b1);
        check("b2b_overrun_cycles", ov_cycles - ov_before, 1);
        accept_word();
        tick_wait(2);
        check("b2b_stays_clear", rx_valid, 1'b0);

        // Leave a word held, then reset in the middle of data bit 3
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_reset_valid", rx_valid, 1'b1);
        tick_wait(1);
        rx = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            tick_wait(16);
        end
        rx = 1'b0;
        tick_wait(8);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
        rx = 1'b1;
        reset = 1'b1;
        tick_wait(200);
        check("post_rst_no_valid", rx_valid, 1'b0);
        check("post_rst_idle", busy, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_valid", rx_valid, 1'b1);
        accept_word();
        tick_wait(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
